ps2_poly_note_tracker: RTL and testbench
========================================

// Module: ps2_poly_note_tracker
// PURPOSE
//  Polyphonic successor to the single-note PS/2 key decoder. Consumes scan-code
//  bytes from the keyboard receiver and runs a make/break/extended prefix FSM.
//  Tracks up to NUM_VOICES simultaneously held piano keys, each in its own voice
//  slot, with an octave shift. Feeds the tone generators and the loop recorder.
// PARAMETERS
//  NUM_VOICES  4  number of voice slots (1..8)
//  NOTE_W      8  width of a note number; must hold 26 + 12*OCT_MAX
//  OCT_W       2  width of octave register
//  OCT_MAX     3  highest octave value (saturating)
//  OCT_RESET   0  octave value after reset
// PORTS
//  clk         in   1                  system clock (50 MHz)
//  reset       in   1                  synchronous, active-high
//  scan_valid  in   1                  1-cycle pulse: scan_code holds a new byte
//  scan_code   in   8                  received PS/2 byte
//  panic       in   1                  sync clear of all voices (level, sampled each clk)
//  voice_on    out  NUM_VOICES         slot i holds a pressed key
//  voice_note  out  NUM_VOICES*NOTE_W  slot i note at [i*NOTE_W +: NOTE_W]; 0 when off
//  mono_note   out  NOTE_W             note of most recent still-held make; 0 if none
//  octave      out  OCT_W              current octave shift
//  drop        out  1                  1-cycle pulse: make ignored, all slots full
// BEHAVIOUR
//  Reset: voice_on=0, voice_note=0, mono_note=0, octave=OCT_RESET, drop=0, FSM=IDLE,
//   all slot key tags cleared. Reset mid-prefix discards the prefix.
//  Key map (scan->idx): 1A:1 1B:2 22:3 23:4 21:5 2A:6 34:7 32:8 33:9 31:10 3B:11
//   3A:12 41:13 15:14 1E:15 1D:16 26:17 24:18 2D:19 2E:20 2C:21 36:22 35:23 3D:24
//   3C:25 43:26; everything else unmapped. note = idx + 12*octave, latched at make.
//  FSM (advances only on scan_valid):
//   IDLE: F0->BREAK; E0->EXT; mapped->MAKE action; 4E->octave-1; 55->octave+1;
//    other bytes ignored; stay IDLE.
//   BREAK: F0->BREAK (repeated prefix tolerated); E0->EXT; any other byte->BREAK action, IDLE.
//   EXT: F0->EXT_BREAK; any other byte ignored, IDLE.
//   EXT_BREAK: any byte ignored, IDLE. Extended keys never produce notes.
//  MAKE action: if a slot is tagged with this scan code (typematic repeat) -> no change.
//   Else the lowest-index free slot takes tag, note, voice_on=1, and mono_note=note.
//   If no slot is free -> state unchanged, drop pulses for one cycle.
//  BREAK action: slot tagged with the code clears (voice_on=0, note=0, tag cleared).
//   If that note equals mono_note, mono_note=0. No slot matches -> ignored.
//   Break of 4E/55 -> ignored.
//  Octave: saturates at 0 and OCT_MAX; a change affects only subsequent makes.
//   Held voices keep their latched note.
//  Latency: all outputs registered; they update on the clk edge after the edge
//   that samples scan_valid=1 (1 cycle).
//  panic=1: clears all voices, tags and mono_note that cycle. FSM and octave are
//   kept. A scan_valid in the same cycle is processed by the FSM, but its
//   make/break action is suppressed.
//  reset has priority over panic, and panic has priority over scan_valid.
//  scan_valid asserted on consecutive cycles: each byte is processed in order.
// TESTING
//  1 reset, send 1A -> voice_on=0001, slot0 note=1, mono_note=1; F0 1A -> all 0.
//  2 send 1A,22,21,2A,31 (NUM_VOICES=4) -> slots notes 1,3,5,6; 5th make: drop
//    pulses 1 cycle; F0 22 -> voice_on=1101; 31 -> slot1 note=10.
//  3 55,55,55,55 -> octave=3 (saturates); 1A -> note 37; 4E x5 -> octave=0,
//    held slot still 37.
//  4 1A,1A,1A (typematic) -> only slot0 used; E0 F0 1A -> no change;
//    E0 1A -> no change; F0 F0 1A -> slot0 cleared.
//  5 1A,22 -> mono_note=3; F0 22 -> mono_note=0, slot0 still 1; F0 1A (unheld
//    again) ignored.
//  6 send F0, then assert reset, then send 1A -> slot0 note=1 (prefix
//    discarded); panic with held notes -> all voices cleared, octave kept.

Source files
------------

// File: rtl/ps2_poly_note_tracker.sv
// PS/2 scan-code decoder that allocates held piano keys to NUM_VOICES voice slots.
// Handles make/break/extended prefixes, a saturating octave shift and panic clear.
module ps2_poly_note_tracker #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 8,
  parameter int OCT_W      = 2,
  parameter int OCT_MAX    = 3,
  parameter int OCT_RESET  = 0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           scan_valid_i,
  input  logic [7:0]                     scan_code_i,
  input  logic                           panic_i,
  output logic [NUM_VOICES-1:0]          voice_on_o,
  output logic [NUM_VOICES*NOTE_W-1:0]   voice_note_o,
  output logic [NOTE_W-1:0]              mono_note_o,
  output logic [OCT_W-1:0]               octave_o,
  output logic                           drop_o
);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

  state_t                               state_q, state_d;
  logic [NUM_VOICES-1:0]                on_q, on_d;
  logic [NUM_VOICES-1:0][NOTE_W-1:0]    note_q, note_d;
  logic [NUM_VOICES-1:0][7:0]           tag_q, tag_d;
  logic [NOTE_W-1:0]                    mono_q, mono_d;
  logic [OCT_W-1:0]                     oct_q, oct_d;
  logic                                 drop_q, drop_d;

  function automatic logic [4:0] key_idx(input logic [7:0] c);
    case (c)
      8'h1A: key_idx = 5'd1;   8'h1B: key_idx = 5'd2;   8'h22: key_idx = 5'd3;
      8'h23: key_idx = 5'd4;   8'h21: key_idx = 5'd5;   8'h2A: key_idx = 5'd6;
      8'h34: key_idx = 5'd7;   8'h32: key_idx = 5'd8;   8'h33: key_idx = 5'd9;
      8'h31: key_idx = 5'd10;  8'h3B: key_idx = 5'd11;  8'h3A: key_idx = 5'd12;
      8'h41: key_idx = 5'd13;  8'h15: key_idx = 5'd14;  8'h1E: key_idx = 5'd15;
      8'h1D: key_idx = 5'd16;  8'h26: key_idx = 5'd17;  8'h24: key_idx = 5'd18;
      8'h2D: key_idx = 5'd19;  8'h2E: key_idx = 5'd20;  8'h2C: key_idx = 5'd21;
      8'h36: key_idx = 5'd22;  8'h35: key_idx = 5'd23;  8'h3D: key_idx = 5'd24;
      8'h3C: key_idx = 5'd25;  8'h43: key_idx = 5'd26;
      default: key_idx = 5'd0;
    endcase
  endfunction

  logic [4:0]        idx;
  logic [NOTE_W-1:0] new_note;
  logic              do_make, do_break, hit, placed;

  assign idx      = key_idx(scan_code_i);
  assign new_note = NOTE_W'(idx) + NOTE_W'(oct_q) * NOTE_W'(12);

  always_comb begin
    state_d  = state_q;
    on_d     = on_q;
    note_d   = note_q;
    tag_d    = tag_q;
    mono_d   = mono_q;
    oct_d    = oct_q;
    drop_d   = 1'b0;
    do_make  = 1'b0;
    do_break = 1'b0;
    hit      = 1'b0;
    placed   = 1'b0;

    if (scan_valid_i) begin
      case (state_q)
        S_IDLE: begin
          if (scan_code_i == 8'hF0)      state_d = S_BREAK;
          else if (scan_code_i == 8'hE0) state_d = S_EXT;
          else if (scan_code_i == 8'h4E) begin
            if (oct_q != '0) oct_d = oct_q - 1'b1;
          end else if (scan_code_i == 8'h55) begin
            if (oct_q < OCT_W'(OCT_MAX)) oct_d = oct_q + 1'b1;
          end else if (idx != 5'd0) do_make = 1'b1;
        end
        S_BREAK: begin
          if (scan_code_i == 8'hE0)      state_d = S_EXT;
          else if (scan_code_i != 8'hF0) begin
            do_break = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_EXT:   state_d = (scan_code_i == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // panic still lets the prefix FSM advance, but swallows the key action
    if (do_make && !panic_i) begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (on_q[i] && tag_q[i] == scan_code_i) hit = 1'b1;
      if (!hit) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (!on_q[i] && !placed) begin
            placed    = 1'b1;
            on_d[i]   = 1'b1;
            tag_d[i]  = scan_code_i;
            note_d[i] = new_note;
            mono_d    = new_note;
          end
        end
        if (!placed) drop_d = 1'b1;
      end
    end

    if (do_break && !panic_i) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (on_q[i] && tag_q[i] == scan_code_i) begin
          on_d[i]   = 1'b0;
          tag_d[i]  = '0;
          note_d[i] = '0;
          if (note_q[i] == mono_q) mono_d = '0;
        end
      end
    end

    if (panic_i) begin
      on_d   = '0;
      note_d = '0;
      tag_d  = '0;
      mono_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      on_q    <= '0;
      note_q  <= '0;
      tag_q   <= '0;
      mono_q  <= '0;
      oct_q   <= OCT_W'(OCT_RESET);
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      on_q    <= on_d;
      note_q  <= note_d;
      tag_q   <= tag_d;
      mono_q  <= mono_d;
      oct_q   <= oct_d;
      drop_q  <= drop_d;
    end
  end

  assign voice_on_o   = on_q;
  assign voice_note_o = note_q;
  assign mono_note_o  = mono_q;
  assign octave_o     = oct_q;
  assign drop_o       = drop_q;

endmodule

// File: tb/tb_ps2_poly_note_tracker.sv
// Directed bench for ps2_poly_note_tracker: byte sequences with hand-computed
// expected voice slots, mono note, octave and drop pulse.
module tb_ps2_poly_note_tracker;
  localparam int NV = 4;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          reset, scan_valid, panic;
  logic [7:0]    scan_code;
  logic [NV-1:0] voice_on;
  logic [NV*NW-1:0] voice_note;
  logic [NW-1:0] mono_note;
  logic [1:0]    octave;
  logic          drop;

  int vec = 0;
  int miss = 0;

  ps2_poly_note_tracker #(.NUM_VOICES(NV), .NOTE_W(NW), .OCT_W(2), .OCT_MAX(3), .OCT_RESET(0)) dut (
    .clk_i(clk), .reset_i(reset), .scan_valid_i(scan_valid), .scan_code_i(scan_code),
    .panic_i(panic), .voice_on_o(voice_on), .voice_note_o(voice_note),
    .mono_note_o(mono_note), .octave_o(octave), .drop_o(drop)
  );

  always #10 clk = ~clk;

  // inputs change on negedge; outputs are compared on the following negedge
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_valid = 1'b1; scan_code = b;
    @(negedge clk);
    scan_valid = 1'b0; scan_code = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [NW-1:0] slot(input int i);
    return voice_note[i*NW +: NW];
  endfunction

  task automatic test_reset();
    do_reset();
    vec++;
    if ({voice_on, voice_note, mono_note, octave, drop} !== '0) begin
      miss++; $display("FAIL reset_state on=%b notes=%h mono=%0d oct=%0d drop=%b",
                       voice_on, voice_note, mono_note, octave, drop);
    end
  endtask

  task automatic test_single();
    do_reset();
    send(8'h1A);
    vec++;
    if (voice_on !== 4'b0001 || slot(0) !== 8'd1 || mono_note !== 8'd1) begin
      miss++; $display("FAIL single_make on=%b n0=%0d mono=%0d want 0001/1/1", voice_on, slot(0), mono_note);
    end
    send(8'hF0); send(8'h1A);
    vec++;
    if (voice_on !== 4'b0000 || voice_note !== '0 || mono_note !== 8'd0) begin
      miss++; $display("FAIL single_break on=%b notes=%h mono=%0d want all 0", voice_on, voice_note, mono_note);
    end
  endtask

  task automatic test_full();
    do_reset();
    send(8'h1A); send(8'h22); send(8'h21); send(8'h2A);
    vec++;
    if (voice_on !== 4'b1111 || voice_note !== 32'h06050301 || mono_note !== 8'd6) begin
      miss++; $display("FAIL four_voices on=%b notes=%h mono=%0d want 1111/06050301/6", voice_on, voice_note, mono_note);
    end
    send(8'h31);
    vec++;
    if (drop !== 1'b1 || voice_note !== 32'h06050301 || mono_note !== 8'd6) begin
      miss++; $display("FAIL drop_pulse drop=%b notes=%h mono=%0d want 1/06050301/6", drop, voice_note, mono_note);
    end
    @(negedge clk);
    vec++;
    if (drop !== 1'b0) begin
      miss++; $display("FAIL drop_one_cycle drop=%b want 0", drop);
    end
    send(8'hF0); send(8'h22);
    vec++;
    if (voice_on !== 4'b1101 || slot(1) !== 8'd0 || mono_note !== 8'd6) begin
      miss++; $display("FAIL free_slot1 on=%b n1=%0d mono=%0d want 1101/0/6", voice_on, slot(1), mono_note);
    end
    send(8'h31);
    vec++;
    if (voice_on !== 4'b1111 || slot(1) !== 8'd10 || mono_note !== 8'd10 || drop !== 1'b0) begin
      miss++; $display("FAIL reuse_slot1 on=%b n1=%0d mono=%0d drop=%b want 1111/10/10/0", voice_on, slot(1), mono_note, drop);
    end
  endtask

  task automatic test_octave();
    do_reset();
    repeat (4) send(8'h55);
    vec++;
    if (octave !== 2'd3) begin
      miss++; $display("FAIL octave_sat_hi oct=%0d want 3", octave);
    end
    send(8'h1A);
    vec++;
    if (slot(0) !== 8'd37 || mono_note !== 8'd37) begin
      miss++; $display("FAIL octave_note n0=%0d mono=%0d want 37/37", slot(0), mono_note);
    end
    repeat (5) send(8'h4E);
    vec++;
    if (octave !== 2'd0 || slot(0) !== 8'd37 || voice_on !== 4'b0001) begin
      miss++; $display("FAIL octave_sat_lo oct=%0d n0=%0d on=%b want 0/37/0001", octave, slot(0), voice_on);
    end
    send(8'hF0); send(8'h4E);
    vec++;
    if (octave !== 2'd0 || voice_on !== 4'b0001) begin
      miss++; $display("FAIL octave_break oct=%0d on=%b want 0/0001", octave, voice_on);
    end
  endtask

  task automatic test_prefix();
    do_reset();
    send(8'h1A); send(8'h1A); send(8'h1A);
    vec++;
    if (voice_on !== 4'b0001 || voice_note !== 32'h00000001) begin
      miss++; $display("FAIL typematic on=%b notes=%h want 0001/00000001", voice_on, voice_note);
    end
    send(8'hE0); send(8'hF0); send(8'h1A);
    send(8'hE0); send(8'h1A);
    vec++;
    if (voice_on !== 4'b0001 || voice_note !== 32'h00000001 || mono_note !== 8'd1) begin
      miss++; $display("FAIL extended_ignored on=%b notes=%h mono=%0d want 0001/00000001/1", voice_on, voice_note, mono_note);
    end
    send(8'hF0); send(8'hF0); send(8'h1A);
    vec++;
    if (voice_on !== 4'b0000 || voice_note !== '0 || mono_note !== 8'd0) begin
      miss++; $display("FAIL double_f0_break on=%b notes=%h mono=%0d want 0", voice_on, voice_note, mono_note);
    end
  endtask

  task automatic test_mono();
    do_reset();
    send(8'h1A); send(8'h22);
    vec++;
    if (mono_note !== 8'd3) begin
      miss++; $display("FAIL mono_latest mono=%0d want 3", mono_note);
    end
    send(8'hF0); send(8'h22);
    vec++;
    if (mono_note !== 8'd0 || slot(0) !== 8'd1 || voice_on !== 4'b0001) begin
      miss++; $display("FAIL mono_release mono=%0d n0=%0d on=%b want 0/1/0001", mono_note, slot(0), voice_on);
    end
    send(8'hF0); send(8'h1A);
    send(8'hF0); send(8'h1A);
    send(8'h22);
    vec++;
    if (voice_on !== 4'b0001 || slot(0) !== 8'd3 || mono_note !== 8'd3) begin
      miss++; $display("FAIL unheld_break on=%b n0=%0d mono=%0d want 0001/3/3", voice_on, slot(0), mono_note);
    end
  endtask

  task automatic test_reset_prefix_panic();
    do_reset();
    send(8'hF0);
    do_reset();
    send(8'h1A);
    vec++;
    if (voice_on !== 4'b0001 || slot(0) !== 8'd1) begin
      miss++; $display("FAIL reset_mid_prefix on=%b n0=%0d want 0001/1", voice_on, slot(0));
    end
    send(8'h55); send(8'h22);
    @(negedge clk); panic = 1'b1;
    @(negedge clk); panic = 1'b0;
    vec++;
    if (voice_on !== 4'b0000 || voice_note !== '0 || mono_note !== 8'd0 || octave !== 2'd1) begin
      miss++; $display("FAIL panic_clear on=%b notes=%h mono=%0d oct=%0d want 0/0/0/1", voice_on, voice_note, mono_note, octave);
    end
    // make arriving with panic is dropped
    @(negedge clk); panic = 1'b1; scan_valid = 1'b1; scan_code = 8'h22;
    @(negedge clk); panic = 1'b0; scan_valid = 1'b0;
    vec++;
    if (voice_on !== 4'b0000) begin
      miss++; $display("FAIL panic_make on=%b want 0000", voice_on);
    end
    // F0 arriving with panic still moves FSM to BREAK, so next 1A is a break
    @(negedge clk); panic = 1'b1; scan_valid = 1'b1; scan_code = 8'hF0;
    @(negedge clk); panic = 1'b0; scan_valid = 1'b0;
    send(8'h1A);
    vec++;
    if (voice_on !== 4'b0000 || mono_note !== 8'd0) begin
      miss++; $display("FAIL panic_fsm on=%b mono=%0d want 0000/0", voice_on, mono_note);
    end
    send(8'h1A);
    vec++;
    if (voice_on !== 4'b0001 || slot(0) !== 8'd13) begin
      miss++; $display("FAIL panic_octave_kept on=%b n0=%0d want 0001/13", voice_on, slot(0));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4];
    seq = '{8'h1A, 8'h22, 8'hF0, 8'h1A};
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      scan_valid = 1'b1; scan_code = seq[i];
      @(negedge clk);
    end
    scan_valid = 1'b0;
    vec++;
    if (voice_on !== 4'b0010 || voice_note !== 32'h00000300 || mono_note !== 8'd3) begin
      miss++; $display("FAIL back_to_back on=%b notes=%h mono=%0d want 0010/00000300/3", voice_on, voice_note, mono_note);
    end
  endtask

  initial begin
    reset = 1'b1; scan_valid = 1'b0; scan_code = 8'h00; panic = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_octave();
    test_prefix();
    test_mono();
    test_reset_prefix_panic();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
